math_cabs_arb: RTL

MATH_CABS_ARB -- requirements
Module: math_cabs_arb

---
 rtl/math_pkg.sv | 43 ++++
 rtl/math_cabs_32.sv | 52 +++++
 rtl/math_cabs_arb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// Shared constants, the result-tag type and the integer square-root step
// used by the complex-magnitude arbiter slice.
package math_pkg;

  localparam int CABS_LAT   = 14;
  localparam int CABS_IN_W  = 32;
  localparam int CABS_OUT_W = 34;
  localparam int CABS_CH_W  = 3;

  // Travels alongside each sample so the result can be routed back to its channel.
  typedef struct packed {
    logic                 valid;
    logic [CABS_CH_W-1:0] ch;
  } cabs_tag_t;

  // Working state of the digit-by-digit square root: the radicand still to be
  // consumed (two bits per step, MSB first), the partial remainder and the root.
  typedef struct packed {
    logic [63:0] x;
    logic [33:0] rem;
    logic [31:0] root;
  } cabs_sqrt_t;

  // One restoring square-root step: bring down two radicand bits and try the
  // next root bit. The remainder never exceeds 2*root, so 34 bits hold it.
  function automatic cabs_sqrt_t sqrtStep(input cabs_sqrt_t s);
    cabs_sqrt_t  n;
    logic [35:0] rem2;
    logic [35:0] trial;
    rem2  = {s.rem, s.x[63:62]};
    trial = {2'b00, s.root, 2'b01};
    n.x   = {s.x[61:0], 2'b00};
    if (rem2 >= trial) begin
      n.rem  = 34'(rem2 - trial);
      n.root = {s.root[30:0], 1'b1};
    end else begin
      n.rem  = 34'(rem2);
      n.root = {s.root[30:0], 1'b0};
    end
    return n;
  endfunction

endpackage

// File: rtl/math_cabs_32.sv
// Pipelined complex magnitude: dout = floor(sqrt(dina^2 + dinb^2)).
// Stage 0 forms the 64-bit sum of squares; the remaining LAT-1 stages run the
// 32 square-root steps, spread evenly. LAT must be at least 2.
module math_cabs_32
  import math_pkg::*;
#(
  parameter int LAT = CABS_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic signed [CABS_IN_W-1:0]  dina,
  input  logic signed [CABS_IN_W-1:0]  dinb,
  output logic        [CABS_OUT_W-1:0] dout
);

  localparam int ITER = (32 + LAT - 2) / (LAT - 1);

  cabs_sqrt_t         st_q [LAT];
  cabs_sqrt_t         st_d [LAT];
  logic signed [63:0] sqA;
  logic signed [63:0] sqB;

  // Next value of every stage: squares into stage 0, a slice of root steps per later stage.
  always_comb begin
    sqA = 64'(dina) * 64'(dina);
    sqB = 64'(dinb) * 64'(dinb);
    st_d[0].x    = unsigned'(sqA) + unsigned'(sqB);
    st_d[0].rem  = '0;
    st_d[0].root = '0;
    for (int k = 1; k < LAT; k++) begin
      st_d[k] = st_q[k-1];
      for (int m = 0; m < ITER; m++) begin
        if (((k - 1) * ITER + m) < 32) begin
          st_d[k] = sqrtStep(st_d[k]);
        end
      end
    end
  end

  // Pipeline registers advance only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) st_q[k] <= '0;
    end else if (ena) begin
      for (int k = 0; k < LAT; k++) st_q[k] <= st_d[k];
    end
  end

  assign dout = CABS_OUT_W'(st_q[LAT-1].root);

endmodule

// File: rtl/math_cabs_arb.sv
// Round-robin arbiter sharing one math_cabs_32 among NUM_CH channels.
// Each result comes back 1+LAT enabled cycles after its grant, tagged with
// its channel. Build option MATH_CABS_ARB_STATS_EN adds saturating 16-bit
// per-channel grant counters on stat_cnt; otherwise stat_cnt is zero.
module math_cabs_arb
  import math_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LAT    = CABS_LAT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic [NUM_CH-1:0]              in_valid,
  output logic [NUM_CH-1:0]              in_ready,
  input  logic [CABS_IN_W*NUM_CH-1:0]    in_dina,
  input  logic [CABS_IN_W*NUM_CH-1:0]    in_dinb,
  output logic [CABS_OUT_W-1:0]          dout,
  output logic                           dout_valid,
  output logic [$clog2(NUM_CH)-1:0]      dout_ch,
  output logic                           busy,
  output logic [16*NUM_CH-1:0]           stat_cnt
);

  localparam int CW = $clog2(NUM_CH);
  localparam int FW = $clog2(LAT + 3);

  logic [CW-1:0]               rrPtr_q, rrPtr_d;
  logic [CW-1:0]               grantIdx;
  logic [NUM_CH-1:0]           grant;
  logic                        anyValid;
  logic                        rstDly_q;
  logic                        readyEn;
  logic                        xfer;
  logic signed [CABS_IN_W-1:0] inA_q, inB_q;
  cabs_tag_t                   tag_q [LAT+1];
  logic [FW-1:0]               inFlight_q, inFlight_d;
  int                          idx;

  // Search from rrPtr; descending offsets so the nearest valid channel wins.
  always_comb begin
    grantIdx = '0;
    anyValid = 1'b0;
    idx      = 0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      idx = int'(rrPtr_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (in_valid[idx]) begin
        grantIdx = CW'(idx);
        anyValid = 1'b1;
      end
    end
    grant = anyValid ? (NUM_CH'(1) << grantIdx) : '0;
  end

  // No grants while disabled, in reset, or in the first cycle after reset.
  assign readyEn  = ena & ~rst & ~rstDly_q;
  assign in_ready = readyEn ? grant : '0;
  assign xfer     = readyEn & anyValid;

  // Pointer moves just past the channel that transferred, wrapping at NUM_CH.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (xfer) rrPtr_d = (grantIdx == CW'(NUM_CH - 1)) ? '0 : grantIdx + CW'(1);
  end

  // Remembers that the previous cycle was in reset, to hold off grants one more cycle.
  always_ff @(posedge clk) begin
    rstDly_q <= rst;
  end

  // Arbiter pointer, input operand stage and channel tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q <= '0;
      inA_q   <= '0;
      inB_q   <= '0;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else if (ena) begin
      rrPtr_q  <= rrPtr_d;
      inA_q    <= xfer ? in_dina[grantIdx*CABS_IN_W +: CABS_IN_W] : '0;
      inB_q    <= xfer ? in_dinb[grantIdx*CABS_IN_W +: CABS_IN_W] : '0;
      tag_q[0] <= '{valid: xfer, ch: xfer ? CABS_CH_W'(grantIdx) : '0};
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  math_cabs_32 #(.LAT(LAT)) uCabs (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .dina (inA_q),
    .dinb (inB_q),
    .dout (dout)
  );

  assign dout_valid = tag_q[LAT].valid;
  assign dout_ch    = tag_q[LAT].ch[CW-1:0];

  // In-flight count: up on a transfer, down on a retiring result, both at once cancel.
  always_comb begin
    inFlight_d = inFlight_q;
    case ({xfer, ena & dout_valid})
      2'b10:   inFlight_d = inFlight_q + FW'(1);
      2'b01:   inFlight_d = inFlight_q - FW'(1);
      default: inFlight_d = inFlight_q;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge clk) begin
    if (rst) inFlight_q <= '0;
    else if (ena) inFlight_q <= inFlight_d;
  end

  assign busy = (inFlight_q != '0);

`ifdef MATH_CABS_ARB_STATS_EN
  logic [15:0] stat_q [NUM_CH];

  // Per-channel grant counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
    end else if (xfer && (stat_q[grantIdx] != 16'hFFFF)) begin
      stat_q[grantIdx] <= stat_q[grantIdx] + 16'd1;
    end
  end

  // Pack the counters onto the flat output bus.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) stat_cnt[16*i +: 16] = stat_q[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule
